// File: rtl/cache_ri_refill.sv
// cache_ri_refill: miss and uncached-IO service engine behind the cache
// read/write stage. It refills a 16-word block (writing back a dirty victim
// first), and it performs single-word uncached accesses on the m0 master.
//
//   state    | meaning
//   IDLE     | wait for a command; not accepted while the ready pulse is high
//   IO_RQ    | uncached read/write strobe held until the slave accepts it
//   IO_WT    | uncached read waiting for read data
//   TAG_RD   | pick the victim way and read its tag
//   TAG_CHK  | tag data valid; a dirty victim goes to writeback, else to fill
//   WB_RD    | present data RAM address of victim word k
//   WB_LD    | capture victim word k from the data RAM
//   WB_WR    | write victim word k to memory
//   FILL_RQ  | read request for block word k
//   FILL_WT  | wait for word k, write it (merged if it is the request word)
//   TAG_WR   | install the new tag, advance round-robin if it was used
//   DONE     | completion; the ready pulse follows on the next cycle
module cache_ri_refill #(
   parameter int SIZE = 8192,
   localparam int DW  = $clog2(SIZE / 16),
   localparam int TAW = DW - 4,
   localparam int TW  = 30 - DW
) (
   input  logic            clk,
   input  logic            rest,
   input  logic [3:0]      ri_cmd,
   input  logic            ri_cmd_valid,
   output logic            ri_cmd_ready,
   output logic [31:0]     ri_rsp_data,
   input  logic [31:0]     rq_address,
   input  logic [3:0]      rq_byteEnable,
   input  logic            rq_write,
   input  logic [31:0]     rq_writeData,
   output logic [31:0]     m0_address,
   output logic [3:0]      m0_byteEnable,
   output logic            m0_read,
   output logic            m0_write,
   output logic [31:0]     m0_writeData,
   input  logic [31:0]     m0_readData,
   input  logic            m0_waitRequest,
   input  logic            m0_readDataValid,
   output logic [TAW-1:0]  tag_ri_address,
   output logic [1:0]      tag_ri_channel,
   input  logic [31:0]     tag_ri_readData,
   output logic            tag_ri_writeEnable,
   output logic [31:0]     tag_ri_writeData,
   input  logic            tag_ri_isHaveFreeBlock,
   input  logic [1:0]      tag_ri_freeBlockNum,
   output logic [DW-1:0]   data_ri_address,
   output logic [1:0]      data_ri_channel,
   input  logic [31:0]     data_ri_readData,
   output logic            data_ri_writeEnable,
   output logic [31:0]     data_ri_writeData,
   output logic [DW-2:0]   dre_ri_writeAddress,
   output logic            dre_ri_writeEnable
);

   localparam logic [3:0] CMD_NOP  = 4'd0;
   localparam logic [3:0] CMD_RB   = 4'd1;
   localparam logic [3:0] CMD_IORW = 4'd2;
   localparam logic [3:0] CMD_CTR  = 4'd3;

   typedef enum logic [3:0] {
      IDLE, IO_RQ, IO_WT, TAG_RD, TAG_CHK, WB_RD, WB_LD, WB_WR,
      FILL_RQ, FILL_WT, TAG_WR, DONE
   } state_t;

   state_t            state_q, state_nx;
   logic [3:0]        k_q;
   logic [1:0]        rr_q;
   logic [1:0]        way_q;
   logic              used_free_q;
   logic [TW-1:0]     vtag_q;
   logic [31:0]       wb_data_q;
   logic [31:0]       rsp_q;

   logic [TAW-1:0]    set_idx;
   logic [1:0]        way_sel;
   logic              word_hit;
   logic [31:0]       merged;
   logic [31:0]       fill_word;
   logic              unused_bits;

   assign set_idx   = rq_address[DW+1:6];
   assign way_sel   = tag_ri_isHaveFreeBlock ? tag_ri_freeBlockNum : rr_q;
   assign word_hit  = (k_q == rq_address[5:2]);
   assign fill_word = (word_hit && rq_write) ? merged : m0_readData;
   assign unused_bits = ^{tag_ri_readData[29:TW], rq_address[1:0]};

   // byte-lane merge of the store data into the word coming back from memory
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         merged[b*8 +: 8] = rq_byteEnable[b] ? rq_writeData[b*8 +: 8] : m0_readData[b*8 +: 8];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rest) state_q <= IDLE;
      else      state_q <= state_nx;
   end

   // next state and all strobes/addresses, decoded from the current state
   always_comb begin
      state_nx            = state_q;
      m0_address          = '0;
      m0_byteEnable       = '0;
      m0_read             = 1'b0;
      m0_write            = 1'b0;
      m0_writeData        = '0;
      tag_ri_address      = '0;
      tag_ri_channel      = '0;
      tag_ri_writeEnable  = 1'b0;
      tag_ri_writeData    = '0;
      data_ri_address     = '0;
      data_ri_channel     = '0;
      data_ri_writeEnable = 1'b0;
      data_ri_writeData   = '0;
      dre_ri_writeAddress = '0;
      dre_ri_writeEnable  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ri_cmd_valid && !ri_cmd_ready) begin
               case (ri_cmd)
                  CMD_IORW:         state_nx = IO_RQ;
                  CMD_RB:           state_nx = TAG_RD;
                  CMD_NOP, CMD_CTR: state_nx = DONE;
                  default:          state_nx = DONE;
               endcase
            end
         end
         IO_RQ: begin
            m0_address    = {rq_address[31:2], 2'b00};
            m0_byteEnable = rq_byteEnable;
            m0_read       = !rq_write;
            m0_write      = rq_write;
            m0_writeData  = rq_writeData;
            if (!m0_waitRequest) state_nx = rq_write ? DONE : IO_WT;
         end
         IO_WT: begin
            if (m0_readDataValid) state_nx = DONE;
         end
         TAG_RD: begin
            tag_ri_address = set_idx;
            tag_ri_channel = way_sel;
            state_nx       = TAG_CHK;
         end
         TAG_CHK: begin
            tag_ri_address = set_idx;
            tag_ri_channel = way_q;
            state_nx       = (tag_ri_readData[31] && tag_ri_readData[30]) ? WB_RD : FILL_RQ;
         end
         WB_RD, WB_LD: begin
            data_ri_address = {set_idx, k_q};
            data_ri_channel = way_q;
            state_nx        = (state_q == WB_RD) ? WB_LD : WB_WR;
         end
         WB_WR: begin
            m0_address    = {vtag_q, set_idx, k_q, 2'b00};
            m0_byteEnable = 4'hF;
            m0_write      = 1'b1;
            m0_writeData  = wb_data_q;
            if (!m0_waitRequest) state_nx = (k_q == 4'd15) ? FILL_RQ : WB_RD;
         end
         FILL_RQ: begin
            m0_address    = {rq_address[31:6], k_q, 2'b00};
            m0_byteEnable = 4'hF;
            m0_read       = 1'b1;
            if (!m0_waitRequest) state_nx = FILL_WT;
         end
         FILL_WT: begin
            data_ri_address     = {set_idx, k_q};
            data_ri_channel     = way_q;
            data_ri_writeData   = fill_word;
            dre_ri_writeAddress = {set_idx, k_q[3:1]};
            if (m0_readDataValid) begin
               data_ri_writeEnable = 1'b1;
               dre_ri_writeEnable  = k_q[0];
               state_nx            = (k_q == 4'd15) ? TAG_WR : FILL_RQ;
            end
         end
         TAG_WR: begin
            tag_ri_address     = set_idx;
            tag_ri_channel     = way_q;
            tag_ri_writeEnable = 1'b1;
            tag_ri_writeData   = {1'b1, rq_write, {(30-TW){1'b0}}, rq_address[31:32-TW]};
            state_nx           = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // word counter, victim capture, response and round-robin bookkeeping
   always_ff @(posedge clk) begin
      if (rest) begin
         k_q          <= '0;
         rr_q         <= '0;
         way_q        <= '0;
         used_free_q  <= 1'b0;
         vtag_q       <= '0;
         wb_data_q    <= '0;
         rsp_q        <= '0;
         ri_cmd_ready <= 1'b0;
         ri_rsp_data  <= '0;
      end else begin
         ri_cmd_ready <= (state_q == DONE);
         ri_rsp_data  <= (state_q == DONE) ? rsp_q : '0;
         case (state_q)
            IDLE: begin
               if (state_nx != IDLE) begin
                  rsp_q <= '0;
                  k_q   <= '0;
               end
            end
            IO_WT: if (m0_readDataValid) rsp_q <= m0_readData;
            TAG_RD: begin
               way_q       <= way_sel;
               used_free_q <= tag_ri_isHaveFreeBlock;
            end
            TAG_CHK: begin
               vtag_q <= tag_ri_readData[TW-1:0];
               k_q    <= '0;
            end
            WB_LD: wb_data_q <= data_ri_readData;
            // k wraps 15 -> 0 so the fill restarts at word 0 after writeback
            WB_WR: if (!m0_waitRequest) k_q <= k_q + 4'd1;
            FILL_WT: begin
               if (m0_readDataValid) begin
                  if (word_hit) rsp_q <= fill_word;
                  k_q <= k_q + 4'd1;
               end
            end
            TAG_WR: if (!used_free_q) rr_q <= rr_q + 2'd1;
            default: ;
         endcase
      end
   end

endmodule
